// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add WORD_SIZE x WORD_SIZE multiplier that borrows the shared ALU for every add and shift.
// Build option: define MUL_EARLY_EXIT_EN to finish as soon as no multiplier bits remain.

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`endif
`ifndef ALU_SHL
`define ALU_SHL  4'h6
`endif
`ifndef ALU_ID_A
`define ALU_ID_A 4'hA
`endif

module alu_seq_multiplier #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] multiplicand,
  input  logic [WORD_SIZE-1:0] multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] product,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_c
);

  localparam int unsigned CNT_W = $clog2(WORD_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);
  localparam logic [3:0] OP_ADD  = `ALU_ADD;
  localparam logic [3:0] OP_SHL  = `ALU_SHL;
  localparam logic [3:0] OP_ID_A = `ALU_ID_A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SHL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] acc;
  logic [WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0] mplr;
  logic [CNT_W-1:0]     cnt;
  logic                 last_c;

  // Final SHL cycle: all bits consumed, or (optionally) nothing left to add
`ifdef MUL_EARLY_EXIT_EN
  assign last_c = (cnt == CNT_LAST) || ((mplr >> 1) == '0);
`else
  assign last_c = (cnt == CNT_LAST);
`endif

  assign product = acc;

  // ALU operands are registered one step ahead so they are stable for the whole state they serve
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      alu_op <= OP_ID_A;
      alu_a  <= '0;
      alu_b  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= multiplicand;
            mplr   <= multiplier;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ADD;
            alu_op <= multiplier[0] ? OP_ADD : OP_ID_A;
            alu_a  <= '0;
            alu_b  <= multiplicand;
          end
        end
        ADD: begin
          if (mplr[0]) begin
            acc <= alu_c;
          end
          state  <= SHL;
          alu_op <= OP_SHL;
          alu_a  <= mcand;
          alu_b  <= '0;
        end
        SHL: begin
          mcand <= alu_c;
          mplr  <= mplr >> 1;
          if (last_c) begin
            state  <= DONE;
            done   <= 1'b1;
            alu_op <= OP_ID_A;
            alu_a  <= '0;
            alu_b  <= '0;
          end else begin
            cnt    <= cnt + 1'b1;
            state  <= ADD;
            alu_op <= mplr[1] ? OP_ADD : OP_ID_A;
            alu_a  <= acc;
            alu_b  <= alu_c;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier with a behavioural model of the shared ALU.

`ifndef ALU_ADD
`define ALU_ADD  4'h0
`endif
`ifndef ALU_SHL
`define ALU_SHL  4'h6
`endif
`ifndef ALU_ID_A
`define ALU_ID_A 4'hA
`endif

module tb_alu_seq_multiplier;

  localparam int unsigned W = 16;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_c;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_multiplier #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_c        (alu_c)
  );

  always #5 clk = ~clk;

  // Shared ALU: SHL shifts A left by one, carry discarded
  always_comb begin
    alu_c = '0;
    case (alu_op)
      `ALU_ADD:  alu_c = alu_a + alu_b;
      `ALU_SHL:  alu_c = {alu_a[W-2:0], 1'b0};
      `ALU_ID_A: alu_c = alu_a;
      default:   alu_c = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_sel(input int full, input int early);
    return EARLY ? early : full;
  endfunction

  // Entered and left at a negedge; k counts cycles after the accepting edge N
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_p, input int lat, input int repulse_edge,
                        input int reset_edge, output int adds);
    int           done_k   = -1;
    int           done_cnt = 0;
    int           busy_err = 0;
    int           last_k;
    logic         exp_busy;
    logic [W-1:0] p_at_done = '0;
    adds = 0;
    start        = 1'b1;
    multiplicand = x;
    multiplier   = y;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    last_k = (reset_edge >= 0) ? 40 : lat + 1;
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k    = k;
          p_at_done = product;
        end
      end
      exp_busy = (reset_edge >= 0) ? (k < reset_edge) : (k <= lat);
      if (busy !== exp_busy) busy_err++;
      if (alu_op == `ALU_ADD) adds++;
      if (k == repulse_edge - 1) begin
        start        = 1'b1;
        multiplicand = 16'd9;
        multiplier   = 16'd9;
      end
      if (k == repulse_edge) start = 1'b0;
      if (k == reset_edge - 1) reset = 1'b1;
      if (k == reset_edge) reset = 1'b0;
    end
    if (reset_edge < 0) begin
      check({tag, ".done_cycle"}, 32'(done_k), 32'(lat));
      check({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, ".product_at_done"}, 32'(p_at_done), 32'(exp_p));
      check({tag, ".product_held"}, 32'(product), 32'(exp_p));
    end else begin
      check({tag, ".done_pulses"}, 32'(done_cnt), 32'd0);
      check({tag, ".product_after_reset"}, 32'(product), 32'(exp_p));
      check({tag, ".alu_op_after_reset"}, 32'(alu_op), 32'(`ALU_ID_A));
    end
    check({tag, ".busy_profile_errors"}, 32'(busy_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int adds;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("rst.busy",    32'(busy),    32'd0);
    check("rst.done",    32'(done),    32'd0);
    check("rst.product", 32'(product), 32'd0);
    check("rst.alu_op",  32'(alu_op),  32'(`ALU_ID_A));
    check("rst.alu_a",   32'(alu_a),   32'd0);
    check("rst.alu_b",   32'(alu_b),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("x3y5",    16'h0003, 16'h0005, 16'h000F, lat_sel(32, 6),  -1, -1, adds);
    check("x3y5.add_used", 32'(adds > 0), 32'd1);
    run_op("ffff",    16'hFFFF, 16'hFFFF, 16'h0001, lat_sel(32, 32), -1, -1, adds);
    run_op("neg3x7",  16'hFFFD, 16'h0007, 16'hFFEB, lat_sel(32, 6),  -1, -1, adds);
    run_op("y0",      16'h1234, 16'h0000, 16'h0000, lat_sel(32, 2),  -1, -1, adds);
    check("y0.no_add", 32'(adds), 32'd0);
    run_op("repulse", 16'h0002, 16'h0003, 16'h0006, lat_sel(32, 4), lat_sel(5, 3), -1, adds);
    run_op("x5y3",    16'h0005, 16'h0003, 16'h000F, lat_sel(32, 4),  -1, -1, adds);
    run_op("abort",   16'h0003, 16'h8005, 16'h0000, 32, -1, 10, adds);
    run_op("post_rst", 16'h0007, 16'h0006, 16'h002A, lat_sel(32, 6), -1, -1, adds);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
